// File: rtl/uno_post_norm.sv
// Post-normalisation for the PE result path: rounds the accumulator, undoes the mode-dependent
// exponent shift and saturates to MUL_BW. Define UNO_POST_NORM_ROUND_NEAREST_EN for round-half-up.
module uno_post_norm #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        gemm_uno,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_BW-1:0] acc_i,
    input  logic [4:0]        shift_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MUL_BW-1:0] out_o,
    output logic              sat_o,
    output logic [7:0]        sat_cnt_o,
    input  logic              sat_clr
);

    localparam int RW = ACC_BW + 1;
    // Wide enough that a 31-bit left shift of the rounded value never loses bits.
    localparam int WW = ACC_BW + 33;

    localparam logic signed [WW-1:0] VMAX = WW'((64'd1 << (MUL_BW - 1)) - 64'd1);
    localparam logic signed [WW-1:0] VMIN = ~VMAX;
    localparam logic [MUL_BW-1:0] OMAX = {1'b0, {(MUL_BW - 1){1'b1}}};
    localparam logic [MUL_BW-1:0] OMIN = {1'b1, {(MUL_BW - 1){1'b0}}};

`ifdef UNO_POST_NORM_ROUND_NEAREST_EN
    localparam logic signed [RW-1:0] RND = RW'(1) << (FRA_BW - 1);
`else
    localparam logic signed [RW-1:0] RND = '0;
`endif

    if (INT_BW + FRA_BW + 1 != MUL_BW) begin : g_cfg_check
        $error("uno_post_norm: MUL_BW must equal INT_BW + FRA_BW + 1");
    end

    logic                     s1_valid_q;
    logic signed [RW-1:0]     s1_r_q;
    logic [4:0]               s1_shift_q;
    logic [1:0]               s1_mode_q;
    logic                     s2_valid_q;
    logic [MUL_BW-1:0]        out_q;
    logic                     sat_q;
    logic [7:0]               sat_cnt_q;

    logic                     s1_adv;
    logic                     s2_adv;
    logic signed [RW-1:0]     acc_ext;
    logic signed [RW-1:0]     sum;
    logic signed [RW-1:0]     r_d;
    logic signed [WW-1:0]     r_wide;
    logic signed [WW-1:0]     v;
    logic [MUL_BW-1:0]        out_d;
    logic                     sat_d;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid_q;
    assign out_o     = out_q;
    assign sat_o     = sat_q;
    assign sat_cnt_o = sat_cnt_q;

    always_comb begin
        acc_ext = {acc_i[ACC_BW-1], acc_i};
        sum     = acc_ext + RND;
        r_d     = sum >>> FRA_BW;
    end

    always_comb begin
        r_wide = {{(WW - RW){s1_r_q[RW-1]}}, s1_r_q};
        v      = r_wide;
        case (s1_mode_q)
            2'b01:   v = r_wide >>> s1_shift_q;
            2'b10:   v = r_wide <<< s1_shift_q;
            default: v = r_wide;
        endcase

        out_d = v[MUL_BW-1:0];
        sat_d = 1'b0;
        if (v > VMAX) begin
            out_d = OMAX;
            sat_d = 1'b1;
        end else if (v < VMIN) begin
            out_d = OMIN;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_shift_q <= '0;
            s1_mode_q  <= '0;
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_r_q     <= r_d;
                    s1_shift_q <= shift_i;
                    s1_mode_q  <= gemm_uno;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_q <= out_d;
                    sat_q <= sat_d;
                end
            end
        end
    end

    // Clear beats a coincident increment; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (s2_valid_q && out_ready && sat_q && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_q <= sat_cnt_q + 8'd1;
        end
    end

endmodule

// File: doc/uno_post_norm.md
Name: uno_post_norm

Overview:
- Output-side counterpart of the PE offset generator: consumes the PE accumulator result together with the exponent captured at operand entry, and returns a MUL_BW fixed-point value.
- The offset generator pre-biases the accumulator (log offset per leading-one position). This block undoes the scaling: it rounds, applies the mode-dependent exponent shift, and saturates.
- Sits between the PE accumulator and the PE result bus.
- Two-stage valid/ready pipeline with a sticky saturation counter.

Parameters:
- INT_BW, 5, integer bits of MUL_BW operand format (Q5.10)
- FRA_BW, 10, fraction bits of operand format; accumulator carries 2*FRA_BW fraction bits
- MUL_BW, 16, output width (signed)
- ACC_BW, 32, accumulator input width (signed)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- gemm_uno  in  2  mode, sampled with in_valid: 00 gemm, 01 div, 10 exp, 11 log
- in_valid  in  1  acc_i/shift_i/gemm_uno valid
- in_ready  out  1  stage 1 can accept
- acc_i  in  ACC_BW  signed accumulator, 2*FRA_BW fraction bits
- shift_i  in  5  exponent from priority encoder of x, 0..31
- out_valid  out  1  out_o valid
- out_ready  in  1  downstream accepts
- out_o  out  MUL_BW  signed result, FRA_BW fraction bits
- sat_o  out  1  out_o was saturated (qualified by out_valid)
- sat_cnt_o  out  8  saturating count of saturated results delivered
- sat_clr  in  1  clears sat_cnt_o

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, out_o=0, sat_o=0, sat_cnt_o=0.
  - Both stage-valid flags cleared; any in-flight data is discarded.
  - in_ready=1 in the cycle after reset deasserts.
- Handshake:
  - Transfer on in_valid&in_ready, and on out_valid&out_ready.
  - Stage k advances when it is empty or stage k+1 advances.
  - in_ready = !s1_valid | s2_advance (combinational from out_ready; no bubble at full throughput).
  - out_o, sat_o and out_valid hold stable while out_valid&!out_ready.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput is 1 result per cycle.
- Stage 1 (round):
  - r = (acc_i + rnd) >>> FRA_BW, arithmetic shift, computed at ACC_BW+1 bits.
  - rnd = 1<<(FRA_BW-1) when ROUND_NEAREST_EN is defined, else 0.
  - Register r, shift_i and mode.
- Stage 2 (scale + saturate):
  - 00 gemm: v = r.
  - 11 log: v = r (offset already added upstream).
  - 01 div: v = r >>> shift_i.
  - 10 exp: v = r <<< shift_i; detect overflow on any bit shifted past sign, using a width of at least ACC_BW+32.
  - If v > 2^(MUL_BW-1)-1: out_o = 0x7FFF, sat_o = 1.
  - If v < -2^(MUL_BW-1): out_o = 0x8000, sat_o = 1.
  - Otherwise out_o = v[MUL_BW-1:0], sat_o = 0.
- Saturation counter:
  - Increments on each output transfer with sat_o=1; sticks at 255.
  - sat_clr has priority over a simultaneous increment, so the result is 0.
  - sat_clr with rst: rst wins.
- Boundaries:
  - shift_i = 0 is the identity shift in all modes.
  - div with shift_i ≥ ACC_BW yields 0 for non-negative r and -1 for negative r.
  - Back-to-back inputs with out_ready low fill both stages; in_ready then drops to 0 in the next cycle, and no data is lost or duplicated.
  - Mode is carried per transaction; a mode change between consecutive inputs affects only the new input.

Optional Feature:
- Macro: UNO_POST_NORM_ROUND_NEAREST_EN.
- Defined: stage 1 adds 1<<(FRA_BW-1) before the shift, giving round-half-up toward +inf.
- Undefined: truncation, i.e. floor via arithmetic shift.
- Both builds use identical latency and handshake.

Test Plan:
- gemm, acc_i=0x0030_0000 (3.0), shift_i=0, out_ready=1 → out_o=0x0C00, sat_o=0, out_valid exactly 2 cycles after accept.
- Rounding, gemm, acc_i=0x0000_0200:
  - Round build → out_o=0x0001.
  - Truncate build → out_o=0x0000.
  - acc_i=0xFFFF_FE00 → 0x0000 round / 0xFFFF truncate.
- exp, acc_i=0x0010_0000 (1.0 → 0x0400):
  - shift_i=3 → out_o=0x2000.
  - shift_i=5 → out_o=0x7FFF, sat_o=1, sat_cnt_o=1.
- div, acc_i=0xFFC0_0000 (-4.0 → 0xF000), shift_i=2 → out_o=0xFC00 (-1.0).
- Backpressure: stream 4 inputs with out_ready=0 → in_ready low after 2 accepts; release out_ready → all 4 outputs appear in order, unchanged, no duplicates.
- Counter: 300 saturating exp results → sat_cnt_o=255; sat_clr and a saturating transfer in the same cycle → 0; rst asserted mid-stream → out_valid=0 next cycle and in-flight items dropped.
